// File: rtl/uart_receiver_if.sv
// Configuration, serial line and received-frame signals between a UART receiver and its user.
interface uart_receiver_if;
  logic [1:0] data_sel;
  logic       parity_en;
  logic       parity_odd;
  logic       stop2;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    output data_sel, parity_en, parity_odd, stop2, rx,
    input  data_out, rx_done, parity_err, frame_err, busy
  );

  modport slave (
    input  data_sel, parity_en, parity_odd, stop2, rx,
    output data_out, rx_done, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: 5-8 data bits, optional parity, 1 or 2 stop bits,
// mid-bit sampling, start-glitch rejection and break handling.
module uart_receiver #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            rx_tick,
  input  logic            reset,
  uart_receiver_if.slave  bus
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, DONE, WAIT_IDLE
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [1:0]             dsel_q, dsel_d;
  logic                   pen_q, pen_d;
  logic                   podd_q, podd_d;
  logic                   stop2_q, stop2_d;
  logic                   perr_acc_q, perr_acc_d;
  logic                   ferr_acc_q, ferr_acc_d;
  logic [7:0]             data_out_q, data_out_d;
  logic                   rx_done_q, rx_done_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;

  logic       rxs;
  logic       sample;
  logic [2:0] last_bit;
  logic       ferr_next;

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign sample   = (tick_q == TICK_LAST);
  assign last_bit = {1'b1, dsel_q};
  assign ferr_next = ferr_acc_q | ~rxs;

  // Next-state and output computation
  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[SYNC_STAGES-2:0], bus.rx};
    tick_d       = tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    dsel_d       = dsel_q;
    pen_d        = pen_q;
    podd_d       = podd_q;
    stop2_d      = stop2_q;
    perr_acc_d   = perr_acc_q;
    ferr_acc_d   = ferr_acc_q;
    data_out_d   = data_out_q;
    rx_done_d    = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    unique case (state_q)
      IDLE: begin
        tick_d     = '0;
        bit_d      = '0;
        shift_d    = '0;
        perr_acc_d = 1'b0;
        ferr_acc_d = 1'b0;
        if (!rxs) begin
          state_d = START;
          dsel_d  = bus.data_sel;
          pen_d   = bus.parity_en;
          podd_d  = bus.parity_odd;
          stop2_d = bus.stop2;
        end
      end
      START: begin
        tick_d = tick_q + TW'(1);
        if (tick_q == TICK_MID) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        tick_d = sample ? '0 : tick_q + TW'(1);
        if (sample) begin
          shift_d[bit_q] = rxs;
          if (bit_q == last_bit) begin
            bit_d   = '0;
            state_d = pen_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        tick_d = sample ? '0 : tick_q + TW'(1);
        if (sample) begin
          perr_acc_d = ((^shift_q) ^ rxs) != podd_q;
          bit_d      = '0;
          state_d    = STOP;
        end
      end
      STOP: begin
        tick_d = sample ? '0 : tick_q + TW'(1);
        if (sample) begin
          ferr_acc_d = ferr_next;
          if (stop2_q && bit_q == 3'd0) begin
            bit_d = 3'd1;
          end else begin
            // Results are published together with the done strobe
            state_d      = DONE;
            rx_done_d    = 1'b1;
            data_out_d   = shift_q;
            parity_err_d = perr_acc_q;
            frame_err_d  = ferr_next;
          end
        end
      end
      DONE: begin
        state_d = ferr_acc_q ? WAIT_IDLE : IDLE;
      end
      WAIT_IDLE: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == START) || (state_d == DATA) || (state_d == PARITY) ||
             (state_d == STOP)  || (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge rx_tick or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sync_q       <= '1;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      dsel_q       <= '0;
      pen_q        <= 1'b0;
      podd_q       <= 1'b0;
      stop2_q      <= 1'b0;
      perr_acc_q   <= 1'b0;
      ferr_acc_q   <= 1'b0;
      data_out_q   <= '0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      dsel_q       <= dsel_d;
      pen_q        <= pen_d;
      podd_q       <= podd_d;
      stop2_q      <= stop2_d;
      perr_acc_q   <= perr_acc_d;
      ferr_acc_q   <= ferr_acc_d;
      data_out_q   <= data_out_d;
      rx_done_q    <= rx_done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.rx_done    = rx_done_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule
